// File: rtl/sensor_debounce.sv
// Two-flop synchroniser and per-channel debounce for 24 sensor pins and 3 buttons, plus a pending-change event queue.
// Pin-to-output latency is DEBOUNCE_CYCLES+2 edges; events are presented until acked and drain one per cycle, lowest channel first.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] raw_sensor,
  input  logic [2:0]  raw_controller,
  output logic [31:0] sensor_input,
  output logic [31:0] controller,
  output logic        evt_valid,
  output logic [4:0]  evt_index,
  output logic        evt_level,
  input  logic        evt_ack,
  output logic        evt_overflow
);

  localparam int               NCH      = 27;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   flip;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   ack_mask;
  logic [CNT_W-1:0] cnt [NCH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {raw_controller, raw_sensor};
      sync2 <= sync1;
    end
  end

  always_comb begin
    flip = '0;
    for (int i = 0; i < NCH; i++) begin
      flip[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Any sample matching the accepted level restarts that channel's count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    evt_index = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) evt_index = 5'(i);
    end
  end

  assign evt_valid = |pending;
  assign evt_level = stable[evt_index];

  always_comb begin
    ack_mask = '0;
    if (evt_ack && evt_valid) ack_mask[evt_index] = 1'b1;
  end

  // A flip landing on an acked bit keeps it pending: the consumer has not seen the newest level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending      <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pending      <= (pending & ~ack_mask) | flip;
      evt_overflow <= evt_overflow | (|(flip & pending));
    end
  end

  assign sensor_input = {8'h00, stable[23:0]};
  assign controller   = {29'h0, stable[26:24]};

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce with DEBOUNCE_CYCLES=4; reference model accepts a level once the last
// DEBOUNCE_CYCLES synchronised samples all differ from the accepted level.
module tb_sensor_debounce;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] raw_sensor = '0;
  logic [2:0]  raw_controller = '0;
  logic        evt_ack = 1'b0;
  logic [31:0] sensor_input;
  logic [31:0] controller;
  logic        evt_valid;
  logic [4:0]  evt_index;
  logic        evt_level;
  logic        evt_overflow;

  always #5 clock = ~clock;

  sensor_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clock(clock),
    .reset(reset),
    .raw_sensor(raw_sensor),
    .raw_controller(raw_controller),
    .sensor_input(sensor_input),
    .controller(controller),
    .evt_valid(evt_valid),
    .evt_index(evt_index),
    .evt_level(evt_level),
    .evt_ack(evt_ack),
    .evt_overflow(evt_overflow)
  );

  logic [71:0] dut_vec;
  assign dut_vec = {sensor_input, controller, evt_valid, evt_index, evt_level, evt_overflow};

  int vectors = 0;
  int miscompares = 0;

  logic [26:0] m_stable;
  logic [26:0] m_pending;
  logic        m_ovf;
  logic [26:0] raw_q[$];
  logic [26:0] seen_q[$];
  logic [71:0] expv;

  function automatic int lowest(input logic [26:0] p);
    int r = 0;
    for (int i = 26; i >= 0; i--) if (p[i]) r = i;
    return r;
  endfunction

  function automatic void model_reset();
    m_stable  = '0;
    m_pending = '0;
    m_ovf     = 1'b0;
    raw_q.delete();
    seen_q.delete();
    repeat (2) raw_q.push_back('0);
    repeat (D) seen_q.push_back('0);
  endfunction

  // raw_q delays pins by two edges; seen_q is the window of samples the debouncer saw at the last D edges.
  function automatic void model_edge(input logic [26:0] raw, input logic ack);
    logic [26:0] flips;
    logic [26:0] ackm;
    raw_q.push_back(raw);
    seen_q.push_back(raw_q.pop_front());
    seen_q.delete(0);
    flips = '1;
    for (int j = 0; j < seen_q.size(); j++) flips &= seen_q[j] ^ m_stable;
    ackm = '0;
    if (ack && m_pending != '0) ackm[lowest(m_pending)] = 1'b1;
    m_ovf     = m_ovf | (|(flips & m_pending));
    m_pending = (m_pending & ~ackm) | flips;
    m_stable  = m_stable ^ flips;
  endfunction

  function automatic logic [71:0] model_out();
    int idx;
    idx = lowest(m_pending);
    return {8'h00, m_stable[23:0], 29'h0, m_stable[26:24], |m_pending, 5'(idx), m_stable[idx], m_ovf};
  endfunction

  task automatic advance();
    @(posedge clock);
    if (!reset) model_edge({raw_controller, raw_sensor}, evt_ack);
    @(negedge clock);
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    model_reset();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    raw_sensor = '1; raw_controller = '0; evt_ack = 1'b0;
    reset = 1'b1; model_reset();
    @(negedge clock);
    vectors++;
    if (dut_vec !== 72'h0) begin miscompares++; $display("FAIL reset_state got=%h exp=0", dut_vec); end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      expv = model_out(); vectors++;
      if (dut_vec !== expv) begin miscompares++; $display("FAIL reset_fill c=%0d got=%h exp=%h", c, dut_vec, expv); end
      advance();
    end
    @(posedge clock);
    model_edge({raw_controller, raw_sensor}, evt_ack);
    #2 reset = 1'b1; model_reset();
    #1;
    vectors++;
    if (dut_vec !== 72'h0) begin miscompares++; $display("FAIL async_reset got=%h exp=0", dut_vec); end
    @(negedge clock);
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      advance();
      vectors++;
      if (sensor_input !== ((e == 6) ? 32'h00FFFFFF : 32'h0)) begin
        miscompares++; $display("FAIL release_edge%0d sensor_input got=%h", e, sensor_input);
      end
    end
    vectors++;
    if (evt_valid !== 1'b1 || evt_index !== 5'd0) begin
      miscompares++; $display("FAIL release_evt got valid=%b idx=%0d exp valid=1 idx=0", evt_valid, evt_index);
    end
    evt_ack = 1'b1;
    for (int c = 0; c < 26; c++) begin
      expv = model_out(); vectors++;
      if (dut_vec !== expv) begin miscompares++; $display("FAIL reset_drain c=%0d got=%h exp=%h", c, dut_vec, expv); end
      advance();
    end
    evt_ack = 1'b0;
    vectors++;
    if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_drained got valid=%b exp 0", evt_valid); end
  endtask

  task automatic test_glitch();
    logic seen_any;
    logic seen_hi;
    raw_sensor = '0; raw_controller = '0; evt_ack = 1'b0;
    sync_reset();
    seen_any = 1'b0;
    raw_sensor[5] = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) raw_sensor[5] = 1'b0;
      expv = model_out(); vectors++;
      if (dut_vec !== expv) begin miscompares++; $display("FAIL glitch3 c=%0d got=%h exp=%h", c, dut_vec, expv); end
      if (sensor_input != 32'h0 || evt_valid) seen_any = 1'b1;
      advance();
    end
    vectors++;
    if (seen_any !== 1'b0) begin miscompares++; $display("FAIL glitch3_reject got change=%b exp 0", seen_any); end
    seen_hi = 1'b0;
    raw_sensor[5] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 5) raw_sensor[5] = 1'b0;
      expv = model_out(); vectors++;
      if (dut_vec !== expv) begin miscompares++; $display("FAIL pulse5 c=%0d got=%h exp=%h", c, dut_vec, expv); end
      if (sensor_input[5]) seen_hi = 1'b1;
      advance();
    end
    vectors++;
    if (seen_hi !== 1'b1) begin miscompares++; $display("FAIL pulse5_accept got seen=%b exp 1", seen_hi); end
  endtask

  task automatic test_simultaneous();
    int exp_idx[3];
    int waited;
    exp_idx = '{3, 24, 26};
    raw_sensor = '0; raw_controller = '0; evt_ack = 1'b0;
    sync_reset();
    raw_controller = 3'b101; raw_sensor = 24'h000008;
    waited = 0;
    while (!evt_valid && waited < 12) begin
      expv = model_out(); vectors++;
      if (dut_vec !== expv) begin miscompares++; $display("FAIL simul_wait got=%h exp=%h", dut_vec, expv); end
      advance(); waited++;
    end
    vectors++;
    if (controller !== 32'h5 || sensor_input !== 32'h8) begin
      miscompares++; $display("FAIL simul_levels got ctl=%h sens=%h exp 5/8 (waited %0d)", controller, sensor_input, waited);
    end
    evt_ack = 1'b1;
    for (int j = 0; j < 3; j++) begin
      vectors++;
      if (evt_valid !== 1'b1 || evt_index !== 5'(exp_idx[j]) || evt_level !== 1'b1) begin
        miscompares++;
        $display("FAIL simul_drain%0d got v=%b idx=%0d lvl=%b exp 1/%0d/1", j, evt_valid, evt_index, evt_level, exp_idx[j]);
      end
      advance();
    end
    evt_ack = 1'b0;
    vectors++;
    if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL simul_empty got valid=%b exp 0", evt_valid); end
  endtask

  task automatic test_overflow();
    raw_sensor = '0; raw_controller = '0; evt_ack = 1'b0;
    sync_reset();
    raw_sensor[7] = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c == 8) raw_sensor[7] = 1'b0;
      expv = model_out(); vectors++;
      if (dut_vec !== expv) begin miscompares++; $display("FAIL overflow_seq c=%0d got=%h exp=%h", c, dut_vec, expv); end
      advance();
    end
    vectors++;
    if (evt_overflow !== 1'b1 || evt_valid !== 1'b1 || evt_index !== 5'd7 || evt_level !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_state got ovf=%b v=%b idx=%0d lvl=%b exp 1/1/7/0", evt_overflow, evt_valid, evt_index, evt_level);
    end
    evt_ack = 1'b1;
    advance();
    evt_ack = 1'b0;
    vectors++;
    if (evt_valid !== 1'b0 || evt_overflow !== 1'b1) begin
      miscompares++; $display("FAIL overflow_single got v=%b ovf=%b exp 0/1", evt_valid, evt_overflow);
    end
  endtask

  task automatic test_collision();
    raw_sensor = '0; raw_controller = '0; evt_ack = 1'b0;
    sync_reset();
    raw_sensor[2] = 1'b1;
    for (int c = 0; c < 8; c++) advance();
    raw_sensor[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      evt_ack = (c == 5);
      expv = model_out(); vectors++;
      if (dut_vec !== expv) begin miscompares++; $display("FAIL collide_seq c=%0d got=%h exp=%h", c, dut_vec, expv); end
      advance();
    end
    evt_ack = 1'b0;
    vectors++;
    if (evt_valid !== 1'b1 || evt_index !== 5'd2 || evt_overflow !== 1'b1 || evt_level !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_state got v=%b idx=%0d ovf=%b lvl=%b exp 1/2/1/0", evt_valid, evt_index, evt_overflow, evt_level);
    end
  endtask

  task automatic test_spurious_ack();
    raw_sensor = '0; raw_controller = '0; evt_ack = 1'b0;
    sync_reset();
    evt_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (dut_vec !== 72'h0) begin miscompares++; $display("FAIL spurious_ack c=%0d got=%h exp=0", c, dut_vec); end
      advance();
    end
    evt_ack = 1'b0;
  endtask

  task automatic test_random();
    int b;
    raw_sensor = '0; raw_controller = '0; evt_ack = 1'b0;
    sync_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, 26);
        if (b < 24) raw_sensor[b] = ~raw_sensor[b];
        else raw_controller[b-24] = ~raw_controller[b-24];
      end
      evt_ack = ($urandom_range(0, 3) == 0);
      expv = model_out(); vectors++;
      if (dut_vec !== expv) begin miscompares++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, expv); end
      advance();
    end
    evt_ack = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_collision();
    test_spurious_ack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
